// File: rtl/scablk_pkg.sv
// Shared types and constants for the SCA block scheduler.
// Optional feature macro used elsewhere in this slice: SCABLK_OVFL_CNT_EN.
package scablk_pkg;

    localparam int unsigned BLKW     = 4;
    localparam int unsigned MAX_NBLK = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OFFER  = 2'd1,
        BUSY   = 2'd2,
        RETURN = 2'd3
    } rd_state_e;

    // Pool sizes are not powers of two, so wrap explicitly at depth-1.
    function automatic logic [BLKW-1:0] ptr_inc(input logic [BLKW-1:0] ptr,
                                                input int unsigned     depth);
        return (ptr == BLKW'(depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

endpackage

// File: rtl/scablk_fifo.sv
// Circular block-index FIFO; optionally preloaded with 1..DEPTH-1 at reset.
// Pointers and count are triplicated and majority-voted when TMR = 1.
module scablk_fifo
    import scablk_pkg::*;
#(
    parameter int unsigned DEPTH    = 12,
    parameter bit          INIT_SEQ = 1'b0,
    parameter bit          TMR      = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_push,
    input  logic [BLKW-1:0] i_din,
    input  logic            i_pop,
    output logic [BLKW-1:0] o_head,
    output logic [4:0]      o_count,
    output logic            o_empty,
    output logic            o_full
);

    localparam logic [BLKW-1:0] WP_INIT  = INIT_SEQ ? BLKW'(DEPTH - 1) : '0;
    localparam logic [4:0]      CNT_INIT = INIT_SEQ ? 5'(DEPTH - 1) : '0;

    logic [BLKW-1:0] r_mem [MAX_NBLK];
    logic [BLKW-1:0] r_wp  [3];
    logic [BLKW-1:0] r_rp  [3];
    logic [4:0]      r_cnt [3];

    logic [BLKW-1:0] w_wp;
    logic [BLKW-1:0] w_rp;
    logic [4:0]      w_cnt;
    logic            w_do_push;
    logic            w_do_pop;

    assign w_wp  = TMR ? ((r_wp[0] & r_wp[1]) | (r_wp[0] & r_wp[2]) | (r_wp[1] & r_wp[2]))
                       : r_wp[0];
    assign w_rp  = TMR ? ((r_rp[0] & r_rp[1]) | (r_rp[0] & r_rp[2]) | (r_rp[1] & r_rp[2]))
                       : r_rp[0];
    assign w_cnt = TMR ? ((r_cnt[0] & r_cnt[1]) | (r_cnt[0] & r_cnt[2]) | (r_cnt[1] & r_cnt[2]))
                       : r_cnt[0];

    assign o_head    = r_mem[w_rp];
    assign o_count   = w_cnt;
    assign o_empty   = (w_cnt == 5'd0);
    assign o_full    = (w_cnt == 5'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && !o_full;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(MAX_NBLK); i++) begin
                r_mem[i] <= (INIT_SEQ && (i < int'(DEPTH) - 1)) ? BLKW'(i + 1) : '0;
            end
            for (int k = 0; k < 3; k++) begin
                r_wp[k]  <= WP_INIT;
                r_rp[k]  <= '0;
                r_cnt[k] <= CNT_INIT;
            end
        end else begin
            if (w_do_push) begin
                r_mem[w_wp] <= i_din;
            end
            // Every copy reloads from the voted value, scrubbing a single upset.
            for (int k = 0; k < 3; k++) begin
                r_wp[k]  <= w_do_push ? ptr_inc(w_wp, DEPTH) : w_wp;
                r_rp[k]  <= w_do_pop ? ptr_inc(w_rp, DEPTH) : w_rp;
                r_cnt[k] <= w_cnt + 5'(w_do_push) - 5'(w_do_pop);
            end
        end
    end

endmodule

// File: rtl/scablk_sched.sv
// SCA block scheduler: free-list / readout-queue management and digitizer grant FSM.
// Define SCABLK_OVFL_CNT_EN to enable the saturating dropped-block counter on OVFLCNT.
module scablk_sched
    import scablk_pkg::*;
#(
    parameter int unsigned NBLK = 12,
    parameter bit          TMR  = 1'b0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            NBSEL,
    input  logic            LCTYENA,
    input  logic            NOLCT,
    input  logic            RDREQ,
    input  logic            RDDONE,
    output logic [BLKW-1:0] WBLK,
    output logic [BLKW-1:0] RBLK,
    output logic            RVALID,
    output logic            RBUSY,
    output logic [4:0]      FREECNT,
    output logic            DSCAFULL,
    output logic            DLSCAFULL,
    output logic            OVFL,
    output logic [7:0]      OVFLCNT
);

    logic [BLKW-1:0] r_wblk, r_rblk;
    logic            r_rvalid, r_rbusy, r_dscafull, r_dlscafull, r_ovfl;
    logic [5:0]      r_st;
    logic [1:0]      w_st_vote;
    rd_state_e       w_state;

    logic [BLKW-1:0] w_free_head, w_q_head;
    logic [4:0]      w_free_cnt, w_free_nxt;
    logic            w_free_empty, w_q_empty;
    logic            w_wr_lct, w_wr_take, w_drop, w_q_pop, w_ret;
    logic            w_unused_free_full, w_unused_q_full, w_unused_nolct;
    logic [4:0]      w_unused_q_cnt;

    // NOLCT only documents a reuse period; the pools ignore it.
    assign w_unused_nolct = NOLCT;

    assign w_st_vote = (r_st[1:0] & r_st[3:2]) | (r_st[1:0] & r_st[5:4]) | (r_st[3:2] & r_st[5:4]);
    assign w_state   = rd_state_e'(TMR ? w_st_vote : r_st[1:0]);

    assign w_wr_lct   = NBSEL && LCTYENA;
    assign w_wr_take  = w_wr_lct && !w_free_empty;
    assign w_drop     = w_wr_lct && w_free_empty;
    assign w_q_pop    = (w_state == OFFER) && RDREQ;
    assign w_ret      = (w_state == RETURN);
    assign w_free_nxt = w_free_cnt + 5'(w_ret) - 5'(w_wr_take);

    scablk_fifo #(.DEPTH(NBLK), .INIT_SEQ(1'b1), .TMR(TMR)) u_free (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (w_ret),
        .i_din   (r_rblk),
        .i_pop   (w_wr_take),
        .o_head  (w_free_head),
        .o_count (w_free_cnt),
        .o_empty (w_free_empty),
        .o_full  (w_unused_free_full)
    );

    scablk_fifo #(.DEPTH(NBLK), .INIT_SEQ(1'b0), .TMR(TMR)) u_rdq (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (w_wr_take),
        .i_din   (r_wblk),
        .i_pop   (w_q_pop),
        .o_head  (w_q_head),
        .o_count (w_unused_q_cnt),
        .o_empty (w_q_empty),
        .o_full  (w_unused_q_full)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wblk      <= '0;
            r_dscafull  <= 1'b0;
            r_dlscafull <= 1'b0;
            r_ovfl      <= 1'b0;
        end else begin
            if (w_wr_take) begin
                r_wblk <= w_free_head;
            end
            if (w_drop) begin
                r_ovfl <= 1'b1;
            end
            r_dscafull  <= (w_free_nxt == 5'd0);
            r_dlscafull <= (w_free_nxt <= 5'd1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_st     <= {3{IDLE}};
            r_rblk   <= '0;
            r_rvalid <= 1'b0;
            r_rbusy  <= 1'b0;
        end else begin
            unique case (w_state)
                IDLE: if (!w_q_empty) begin
                    r_st     <= {3{OFFER}};
                    r_rblk   <= w_q_head;
                    r_rvalid <= 1'b1;
                end
                OFFER: if (RDREQ) begin
                    r_st     <= {3{BUSY}};
                    r_rvalid <= 1'b0;
                    r_rbusy  <= 1'b1;
                end
                BUSY: if (RDDONE) begin
                    r_st    <= {3{RETURN}};
                    r_rbusy <= 1'b0;
                end
                RETURN: r_st <= {3{IDLE}};
            endcase
        end
    end

`ifdef SCABLK_OVFL_CNT_EN
    logic [7:0] r_ovflcnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ovflcnt <= '0;
        end else if (w_drop && (r_ovflcnt != 8'hFF)) begin
            r_ovflcnt <= r_ovflcnt + 8'd1;
        end
    end

    assign OVFLCNT = r_ovflcnt;
`else
    assign OVFLCNT = '0;
`endif

    assign WBLK      = r_wblk;
    assign RBLK      = r_rblk;
    assign RVALID    = r_rvalid;
    assign RBUSY     = r_rbusy;
    assign FREECNT   = w_free_cnt;
    assign DSCAFULL  = r_dscafull;
    assign DLSCAFULL = r_dlscafull;
    assign OVFL      = r_ovfl;

endmodule

// File: tb/tb_scablk_sched.sv
// Directed bench for scablk_sched (NBLK = 12): expected grants are queued as blocks
// are retained and checked by a monitor each time RVALID rises.
module tb_scablk_sched;

`ifdef SCABLK_OVFL_CNT_EN
    localparam int OC_EN = 1;
`else
    localparam int OC_EN = 0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       NBSEL = 1'b0, LCTYENA = 1'b0, NOLCT = 1'b0, RDREQ = 1'b0, RDDONE = 1'b0;
    logic [3:0] WBLK, RBLK;
    logic       RVALID, RBUSY, DSCAFULL, DLSCAFULL, OVFL;
    logic [4:0] FREECNT;
    logic [7:0] OVFLCNT;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q [$];
    logic prev_rvalid = 1'b0;

    // WBLK after each of the 11 retained blocks when the free list reads 4..11,0,1,2.
    int exp_w [11] = '{4, 5, 6, 7, 8, 9, 10, 11, 0, 1, 2};

    scablk_sched #(.NBLK(12), .TMR(1'b0)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .NBSEL     (NBSEL),
        .LCTYENA   (LCTYENA),
        .NOLCT     (NOLCT),
        .RDREQ     (RDREQ),
        .RDDONE    (RDDONE),
        .WBLK      (WBLK),
        .RBLK      (RBLK),
        .RVALID    (RVALID),
        .RBUSY     (RBUSY),
        .FREECNT   (FREECNT),
        .DSCAFULL  (DSCAFULL),
        .DLSCAFULL (DLSCAFULL),
        .OVFL      (OVFL),
        .OVFLCNT   (OVFLCNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic lct_pulse(input int queued);
        exp_q.push_back(queued);
        NBSEL = 1'b1;
        LCTYENA = 1'b1;
        tick();
        NBSEL = 1'b0;
        LCTYENA = 1'b0;
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        while (!RBUSY && n < 30) begin
            tick();
            n++;
        end
        if (!RBUSY) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: RBUSY got 0 after 30 cycles, expected 1", name);
        end
    endtask

    task automatic drain(input int cnt);
        RDREQ = 1'b1;
        for (int i = 0; i < cnt; i++) begin
            wait_busy("drain grant");
            tick();
            tick();
            RDDONE = 1'b1;
            tick();
            RDDONE = 1'b0;
        end
        tick();
        RDREQ = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " WBLK"}, int'(WBLK), 0);
        chk({tag, " RBLK"}, int'(RBLK), 0);
        chk({tag, " FREECNT"}, int'(FREECNT), 11);
        chk({tag, " RVALID"}, int'(RVALID), 0);
        chk({tag, " RBUSY"}, int'(RBUSY), 0);
        chk({tag, " DSCAFULL"}, int'(DSCAFULL), 0);
        chk({tag, " DLSCAFULL"}, int'(DLSCAFULL), 0);
        chk({tag, " OVFL"}, int'(OVFL), 0);
        chk({tag, " OVFLCNT"}, int'(OVFLCNT), 0);
    endtask

    // Scoreboard monitor: every new offer must match the oldest retained block.
    always @(negedge CLK) begin
        if (RVALID && !prev_rvalid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL grant: RBLK got %0d offered, expected no offer", RBLK);
            end else begin
                chk("grant RBLK", int'(RBLK), exp_q.pop_front());
            end
        end
        prev_rvalid <= RVALID;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        chk_reset("reset");
        RST = 1'b0;
        tick();

        // Three retained blocks; queue holds 0,1,2.
        lct_pulse(0);
        lct_pulse(1);
        lct_pulse(2);
        chk("three lct WBLK", int'(WBLK), 3);
        chk("three lct FREECNT", int'(FREECNT), 8);

        // Drain with RDREQ held high; free list becomes 4..11,0,1,2.
        drain(3);
        chk("drained FREECNT", int'(FREECNT), 11);
        chk("drained RVALID", int'(RVALID), 0);

        // NOLCT periods and unqualified LCTYENA leave the pools alone.
        NBSEL = 1'b1;
        NOLCT = 1'b1;
        repeat (20) tick();
        NBSEL = 1'b0;
        NOLCT = 1'b0;
        LCTYENA = 1'b1;
        repeat (3) tick();
        LCTYENA = 1'b0;
        chk("nolct WBLK", int'(WBLK), 3);
        chk("nolct FREECNT", int'(FREECNT), 11);

        // RDREQ/RDDONE in IDLE must not grant.
        RDREQ = 1'b1;
        tick();
        RDREQ = 1'b0;
        RDDONE = 1'b1;
        tick();
        RDDONE = 1'b0;
        tick();
        chk("idle rdreq RVALID", int'(RVALID), 0);
        chk("idle rdreq RBUSY", int'(RBUSY), 0);

        // Fill the pool with no readout; the free-list order exposes the returned tail.
        for (int i = 0; i < 11; i++) begin
            lct_pulse(i == 0 ? 3 : exp_w[i - 1]);
            chk("fill WBLK", int'(WBLK), exp_w[i]);
            chk("fill FREECNT", int'(FREECNT), 10 - i);
            chk("fill DLSCAFULL", int'(DLSCAFULL), (10 - i) <= 1 ? 1 : 0);
            chk("fill DSCAFULL", int'(DSCAFULL), (10 - i) == 0 ? 1 : 0);
        end

        // Twelfth retained block is dropped.
        NBSEL = 1'b1;
        LCTYENA = 1'b1;
        tick();
        NBSEL = 1'b0;
        LCTYENA = 1'b0;
        chk("drop OVFL", int'(OVFL), 1);
        chk("drop WBLK", int'(WBLK), 2);
        chk("drop FREECNT", int'(FREECNT), 0);
        chk("drop OVFLCNT", int'(OVFLCNT), OC_EN);

        // Accept block 3, finish it, and hit RETURN with an LCT while the free list is empty.
        RDREQ = 1'b1;
        tick();
        RDREQ = 1'b0;
        chk("grant3 RBUSY", int'(RBUSY), 1);
        RDDONE = 1'b1;
        tick();
        RDDONE = 1'b0;
        NBSEL = 1'b1;
        LCTYENA = 1'b1;
        tick();
        NBSEL = 1'b0;
        LCTYENA = 1'b0;
        chk("return drop WBLK", int'(WBLK), 2);
        chk("return drop FREECNT", int'(FREECNT), 1);
        chk("return drop DSCAFULL", int'(DSCAFULL), 0);
        chk("return drop DLSCAFULL", int'(DLSCAFULL), 1);
        chk("return drop OVFL", int'(OVFL), 1);
        chk("return drop OVFLCNT", int'(OVFLCNT), 2 * OC_EN);

        // Accept block 4, then reset while BUSY with blocks still queued.
        tick();
        RDREQ = 1'b1;
        tick();
        RDREQ = 1'b0;
        chk("grant4 RBUSY", int'(RBUSY), 1);
        RST = 1'b1;
        #1;
        exp_q.delete();
        chk_reset("midrun reset");
        tick();
        RST = 1'b0;
        tick();

        // Pools are reinitialized: same behaviour as after the first reset.
        lct_pulse(0);
        lct_pulse(1);
        lct_pulse(2);
        chk("post reset WBLK", int'(WBLK), 3);
        chk("post reset FREECNT", int'(FREECNT), 8);
        drain(3);
        chk("post reset drained FREECNT", int'(FREECNT), 11);
        chk("scoreboard left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
